// File: rtl/clock_div_controller.sv
// Clock divider controller: IDLE/RUN/DRAIN sequencing of a programmable
// period counter, one-cycle TICK per period, registered divided clock and a
// one-entry ratio update slot that only takes effect at a period boundary.
// Optional burst mode (fixed number of TICKs per START) is enabled by
// defining CLOCK_DIV_CONTROLLER_BURST_EN.
module clock_div_controller #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 25
) (
    input  logic             input_clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             cfg_valid_i,
    input  logic [WIDTH-1:0] cfg_div_i,
`ifdef CLOCK_DIV_CONTROLLER_BURST_EN
    input  logic [7:0]       burst_len_i,
    output logic             burst_done_o,
`endif
    output logic             cfg_ready_o,
    output logic             cfg_err_o,
    output logic             tick_o,
    output logic             output_clk_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic             pend_v_q, pend_v_d;
    logic [WIDTH-1:0] pend_d_q, pend_d_d;
    logic             cfg_err_q, cfg_err_d;
    logic             out_clk_q, out_clk_d;

    logic busy;
    logic boundary;
    logic xfer;
    logic cfg_bad;
    logic burst_hit;

`ifdef CLOCK_DIV_CONTROLLER_BURST_EN
    logic [7:0] burst_len_q, burst_len_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
`endif

    // Decode of the current period position and the config handshake.
    always_comb begin
        busy     = (state_q != IDLE);
        boundary = busy && (cnt_q == div_a_q - WIDTH'(1));
        xfer     = cfg_valid_i && !pend_v_q;
        cfg_bad  = (cfg_div_i < WIDTH'(2));
`ifdef CLOCK_DIV_CONTROLLER_BURST_EN
        burst_hit = boundary && (burst_len_q != 8'd0) &&
                    (burst_cnt_q == burst_len_q - 8'd1);
`else
        burst_hit = 1'b0;
`endif
    end

    // Next-state logic for sequencing, period counter and ratio slot.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_a_d   = div_a_q;
        pend_v_d  = pend_v_q;
        pend_d_d  = pend_d_q;
        cfg_err_d = xfer && cfg_bad;
        out_clk_d = 1'b0;
`ifdef CLOCK_DIV_CONTROLLER_BURST_EN
        burst_len_d = burst_len_q;
        burst_cnt_d = burst_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // STOP wins over START so a simultaneous pair is a no-op.
                if (start_i && !stop_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
`ifdef CLOCK_DIV_CONTROLLER_BURST_EN
                    burst_len_d = burst_len_i;
                    burst_cnt_d = 8'd0;
`endif
                end
            end
            RUN, DRAIN: begin
                // Divided clock lags the counter by one cycle.
                out_clk_d = (cnt_q < (div_a_q >> 1));
                if (boundary) begin
                    cnt_d = '0;
                    if (pend_v_q) begin
                        div_a_d  = pend_d_q;
                        pend_v_d = 1'b0;
                    end
`ifdef CLOCK_DIV_CONTROLLER_BURST_EN
                    burst_cnt_d = burst_cnt_q + 8'd1;
`endif
                    if (state_q == DRAIN || stop_i || burst_hit) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                    if (state_q == RUN && stop_i) begin
                        state_d = DRAIN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A pending slot only exists while running; in IDLE the ratio is live at once.
        if (xfer && !cfg_bad) begin
            if (state_q == IDLE) begin
                div_a_d = cfg_div_i;
            end else begin
                pend_v_d = 1'b1;
                pend_d_d = cfg_div_i;
            end
        end
    end

    // State registers; reset abandons any period in flight and the pending ratio.
    always_ff @(posedge input_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_a_q   <= DIV_RST;
            pend_v_q  <= 1'b0;
            pend_d_q  <= '0;
            cfg_err_q <= 1'b0;
            out_clk_q <= 1'b0;
`ifdef CLOCK_DIV_CONTROLLER_BURST_EN
            burst_len_q <= 8'd0;
            burst_cnt_q <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_a_q   <= div_a_d;
            pend_v_q  <= pend_v_d;
            pend_d_q  <= pend_d_d;
            cfg_err_q <= cfg_err_d;
            out_clk_q <= out_clk_d;
`ifdef CLOCK_DIV_CONTROLLER_BURST_EN
            burst_len_q <= burst_len_d;
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

    assign tick_o       = boundary;
    assign busy_o       = busy;
    assign cfg_ready_o  = !pend_v_q;
    assign cfg_err_o    = cfg_err_q;
    assign output_clk_o = out_clk_q;
`ifdef CLOCK_DIV_CONTROLLER_BURST_EN
    assign burst_done_o = burst_hit;
`endif

endmodule

// File: tb/tb_clock_div_controller.sv
// Directed bench for clock_div_controller (WIDTH=16, DEFAULT_DIV=25).
module tb_clock_div_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, cfg_valid;
    logic [15:0] cfg_div;
    logic        cfg_ready, cfg_err, tick, out_clk, busy;
`ifdef CLOCK_DIV_CONTROLLER_BURST_EN
    logic [7:0]  burst_len;
    logic        burst_done;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_div_controller #(.WIDTH(16), .DEFAULT_DIV(25)) dut (
        .input_clk_i  (clk),
        .rst_i        (rst),
        .start_i      (start),
        .stop_i       (stop),
        .cfg_valid_i  (cfg_valid),
        .cfg_div_i    (cfg_div),
`ifdef CLOCK_DIV_CONTROLLER_BURST_EN
        .burst_len_i  (burst_len),
        .burst_done_o (burst_done),
`endif
        .cfg_ready_o  (cfg_ready),
        .cfg_err_o    (cfg_err),
        .tick_o       (tick),
        .output_clk_o (out_clk),
        .busy_o       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
`ifdef CLOCK_DIV_CONTROLLER_BURST_EN
        burst_len = 8'd0;
`endif
        #3;
        check_eq("rst_tick",  32'(tick), 0);
        check_eq("rst_oclk",  32'(out_clk), 0);
        check_eq("rst_busy",  32'(busy), 0);
        check_eq("rst_err",   32'(cfg_err), 0);
        check_eq("rst_ready", 32'(cfg_ready), 1);
        step;
        rst = 1'b0;
        step;
        check_eq("idle_busy", 32'(busy), 0);

        // Run at the default ratio 25; reset lands at CNT=12 of the 4th period.
        start = 1'b1;
        step;
        start = 1'b0;
        for (int k = 0; k <= 87; k++) begin
            if (k > 0) step;
            check_eq("a_tick", 32'(tick), 32'(k % 25 == 24));
            check_eq("a_oclk", 32'(out_clk), 32'(k >= 1 && ((k - 1) % 25) < 12));
            check_eq("a_busy", 32'(busy), 1);
        end
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy",  32'(busy), 0);
        check_eq("mid_rst_tick",  32'(tick), 0);
        check_eq("mid_rst_oclk",  32'(out_clk), 0);
        check_eq("mid_rst_ready", 32'(cfg_ready), 1);
        for (int k = 0; k < 3; k++) begin
            step;
            check_eq("rst_hold_tick", 32'(tick), 0);
            check_eq("rst_hold_busy", 32'(busy), 0);
        end
        rst = 1'b0;
        step;

        // Illegal ratios 1 and 0 in IDLE: one error pulse each, ratio kept.
        cfg_valid = 1'b1; cfg_div = 16'd1;
        step;
        cfg_valid = 1'b0;
        check_eq("err1_pulse", 32'(cfg_err), 1);
        check_eq("err1_ready", 32'(cfg_ready), 1);
        step;
        check_eq("err1_clear", 32'(cfg_err), 0);
        cfg_valid = 1'b1; cfg_div = 16'd0;
        step;
        cfg_valid = 1'b0;
        check_eq("err0_pulse", 32'(cfg_err), 1);
        step;
        check_eq("err0_clear", 32'(cfg_err), 0);

        // Ratio 10 offered at CNT=5, ratio 8 offered later, then STOP at CNT=3.
        start = 1'b1;
        step;
        start = 1'b0;
        check_eq("b_busy0", 32'(busy), 1);
        check_eq("b_tick0", 32'(tick), 0);
        for (int k = 1; k <= 95; k++) begin
            step;
            check_eq("b_tick", 32'(tick), 32'(k == 24 || k == 49 ||
                     (k >= 50 && k < 80 && (k - 50) % 10 == 9) ||
                     (k >= 80 && k <= 87 && (k - 80) % 8 == 7)));
            check_eq("b_busy", 32'(busy), 32'(k <= 87));
            check_eq("b_ready", 32'(cfg_ready),
                     32'(!((k >= 31 && k <= 49) || (k >= 72 && k <= 79))));
            check_eq("b_err", 32'(cfg_err), 0);
            if (k == 30) begin cfg_valid = 1'b1; cfg_div = 16'd10; end
            if (k == 31) cfg_valid = 1'b0;
            if (k == 71) begin cfg_valid = 1'b1; cfg_div = 16'd8; end
            if (k == 72) cfg_valid = 1'b0;
            if (k == 83) stop = 1'b1;
            if (k == 84) stop = 1'b0;
        end

        // START and STOP together in IDLE: STOP wins.
        start = 1'b1; stop = 1'b1;
        step;
        start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check_eq("ss_busy", 32'(busy), 0);
            check_eq("ss_tick", 32'(tick), 0);
            step;
        end

        // STOP sampled on the boundary cycle ends the run right after that TICK.
        start = 1'b1;
        step;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step;
            check_eq("f_tick", 32'(tick), 32'(k == 7));
            check_eq("f_busy", 32'(busy), 32'(k <= 7));
            if (k == 7) stop = 1'b1;
            if (k == 8) stop = 1'b0;
        end

`ifdef CLOCK_DIV_CONTROLLER_BURST_EN
        // Burst of 3 TICKs at ratio 4.
        cfg_valid = 1'b1; cfg_div = 16'd4;
        step;
        cfg_valid = 1'b0;
        burst_len = 8'd3;
        start = 1'b1;
        step;
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step;
            check_eq("g_tick", 32'(tick), 32'(k <= 11 && k % 4 == 3));
            check_eq("g_done", 32'(burst_done), 32'(k == 11));
            check_eq("g_busy", 32'(busy), 32'(k <= 11));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
